// File: rtl/fsk_demodulator_if.sv
// Signal bundle between an FSK square-wave source and the demodulator.
// The master drives the carrier; the slave returns the recovered bit, lock and diagnostics.
interface fsk_demodulator_if #(
    parameter int CNT_W = 8
);
    logic             fsk_in_i;
    logic             data_out_o;
    logic             data_valid_o;
    logic             locked_o;
    logic             error_o;
    logic [CNT_W-1:0] half_len_o;

    modport master (
        output fsk_in_i,
        input  data_out_o, data_valid_o, locked_o, error_o, half_len_o
    );

    modport slave (
        input  fsk_in_i,
        output data_out_o, data_valid_o, locked_o, error_o, half_len_o
    );
endinterface

// File: rtl/fsk_demodulator.sv
// FSK demodulator: times each half-period of the synchronised carrier, classifies it
// long (1) or short (0), rejects glitches and carrier loss, and tracks lock.
module fsk_demodulator #(
    parameter int SHORT_HALF  = 32,
    parameter int LONG_HALF   = 128,
    parameter int THRESH      = 80,
    parameter int MIN_HALF    = 16,
    parameter int MAX_HALF    = 192,
    parameter int LOCK_HALVES = 2
) (
    input  logic               clk,
    input  logic               as_reset_n,
    fsk_demodulator_if.slave   bus
);
    localparam int CNT_W = $clog2(MAX_HALF + 1);
    localparam int LCK_W = $clog2(LOCK_HALVES + 1);

    // Nominal half-periods must fall on the correct side of the decision thresholds.
    if (!(MIN_HALF <= SHORT_HALF && SHORT_HALF < THRESH &&
          THRESH <= LONG_HALF && LONG_HALF < MAX_HALF && LOCK_HALVES >= 1)) begin : g_bad_params
        $error("fsk_demodulator: inconsistent half-period parameters");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               s1_q, s2_q, s3_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LCK_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic               data_q, data_d;
    logic               valid_q, valid_d;
    logic               locked_q, locked_d;
    logic               error_q, error_d;
    logic [CNT_W-1:0]   half_len_q, half_len_d;

    logic               edge_w;
    logic [CNT_W-1:0]   cnt_inc;
    logic [LCK_W:0]     lock_sum;

    assign edge_w   = s2_q ^ s3_q;
    assign cnt_inc  = (cnt_q == CNT_W'(MAX_HALF)) ? cnt_q : cnt_q + 1'b1;
    assign lock_sum = {1'b0, lock_cnt_q} + 1'b1;

    always_ff @(posedge clk or negedge as_reset_n) begin
        if (!as_reset_n) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            lock_cnt_q <= '0;
            data_q     <= 1'b0;
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
            error_q    <= 1'b0;
            half_len_q <= '0;
        end else begin
            s1_q       <= bus.fsk_in_i;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lock_cnt_q <= lock_cnt_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            locked_q   <= locked_d;
            error_q    <= error_d;
            half_len_q <= half_len_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_inc;
        lock_cnt_d = lock_cnt_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        locked_d   = locked_q;
        error_d    = 1'b0;
        half_len_d = half_len_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (edge_w) begin
                    state_d = SYNC;
                    cnt_d   = CNT_W'(1);
                end
            end
            default: begin
                // Timeout is checked first so a coincident edge is discarded.
                if (cnt_q == CNT_W'(MAX_HALF)) begin
                    error_d    = 1'b1;
                    locked_d   = 1'b0;
                    lock_cnt_d = '0;
                    cnt_d      = '0;
                    state_d    = IDLE;
                end else if (edge_w) begin
                    cnt_d      = CNT_W'(1);
                    half_len_d = cnt_q;
                    if (cnt_q < CNT_W'(MIN_HALF)) begin
                        error_d    = 1'b1;
                        lock_cnt_d = '0;
                        locked_d   = 1'b0;
                        state_d    = SYNC;
                    end else begin
                        data_d     = (cnt_q >= CNT_W'(THRESH));
                        lock_cnt_d = (lock_sum > (LCK_W+1)'(LOCK_HALVES)) ?
                                     LCK_W'(LOCK_HALVES) : lock_sum[LCK_W-1:0];
                        if (lock_sum >= (LCK_W+1)'(LOCK_HALVES)) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                            valid_d  = 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    assign bus.data_out_o   = data_q;
    assign bus.data_valid_o = valid_q;
    assign bus.locked_o     = locked_q;
    assign bus.error_o      = error_q;
    assign bus.half_len_o   = half_len_q;
endmodule

// File: tb/tb_fsk_demodulator.sv
// Bench for fsk_demodulator: drives carrier half-periods and checks every output each
// cycle against a half-period-level model of lock, decisions, glitches and timeouts.
module tb_fsk_demodulator;
    localparam int MIN_HALF = 16;
    localparam int THRESH   = 80;
    localparam int MAX_HALF = 192;
    localparam int LOCK_N   = 2;
    localparam int LAT      = 3;

    logic clk = 1'b0;
    logic as_reset_n = 1'b0;
    always #5 clk = ~clk;

    fsk_demodulator_if #(.CNT_W(8)) bus ();

    fsk_demodulator dut (
        .clk        (clk),
        .as_reset_n (as_reset_n),
        .bus        (bus.slave)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model state: whether the next transition is only a reference, consecutive legal halves,
    // and the gap preceding the next transition.
    bit m_idle;
    int m_run;
    int m_prev_gap;
    logic       e_data, e_locked, e_dv, e_err;
    logic [7:0] e_len;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s at %0t: observed %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic check_all();
        check("data_out",   32'(bus.data_out_o),   32'(e_data));
        check("data_valid", 32'(bus.data_valid_o), 32'(e_dv));
        check("locked",     32'(bus.locked_o),     32'(e_locked));
        check("error",      32'(bus.error_o),      32'(e_err));
        check("half_len",   32'(bus.half_len_o),   32'(e_len));
    endtask

    task automatic model_reset();
        m_idle = 1'b1; m_run = 0; m_prev_gap = 0;
        e_data = 0; e_locked = 0; e_dv = 0; e_err = 0; e_len = '0;
    endtask

    // Reset pulse: outputs must clear before the next clock; fsk_in toggles during reset.
    task automatic do_reset();
        @(posedge clk); #1;
        as_reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        for (int i = 0; i < 4; i++) begin
            bus.fsk_in_i = ~bus.fsk_in_i;
            @(posedge clk); #1;
            check_all();
        end
        bus.fsk_in_i = 1'b0;
        @(posedge clk); #1;
        as_reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check_all();
        end
    endtask

    // Toggle the carrier, then hold it for g cycles. g must be >= 3 and not in 192..194.
    task automatic drive_half(input int g);
        bit p_dv, p_err, p_lock, p_data;
        logic [7:0] p_len;
        bus.fsk_in_i = ~bus.fsk_in_i;
        p_dv = 0; p_err = 0; p_lock = e_locked; p_data = e_data; p_len = e_len;
        if (m_idle) begin
            m_idle = 1'b0;
            m_run  = 0;
        end else if (m_prev_gap < MIN_HALF) begin
            p_err = 1; p_lock = 0; m_run = 0; p_len = 8'(m_prev_gap);
        end else begin
            p_len  = 8'(m_prev_gap);
            p_data = (m_prev_gap >= THRESH);
            m_run++;
            if (m_run >= LOCK_N) begin
                p_lock = 1; p_dv = 1;
            end
        end
        for (int j = 1; j <= g; j++) begin
            @(posedge clk); #1;
            e_dv = 0; e_err = 0;
            if (j == LAT) begin
                e_dv = p_dv; e_err = p_err; e_locked = p_lock; e_data = p_data; e_len = p_len;
            end
            if (j == MAX_HALF + LAT) begin
                e_err = 1; e_locked = 0; m_run = 0; m_idle = 1'b1;
            end
            check_all();
        end
        m_prev_gap = g;
    endtask

    initial begin
        int r, g;
        bus.fsk_in_i = 1'b0;
        model_reset();

        // Reset with a toggling carrier
        do_reset();

        // Long halves: lock on the 2nd measured edge
        repeat (6) drive_half(128);
        // Short halves: keeps lock
        repeat (6) drive_half(32);
        // Mixed bit stream
        drive_half(128); drive_half(128); drive_half(32); drive_half(32); drive_half(128);
        drive_half(100);

        // Threshold and glitch boundaries, then relock
        drive_half(79); drive_half(80); drive_half(16); drive_half(15);
        drive_half(40); drive_half(40); drive_half(50); drive_half(60);

        // Carrier loss while locked, then relock from IDLE
        drive_half(250);
        repeat (5) drive_half(128);

        // Reset mid-stream, then relock
        drive_half(64);
        do_reset();
        repeat (5) drive_half(32);

        // Randomised half-period stream
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 9));
            case (r)
                0, 1, 2: g = 32;
                3, 4, 5: g = 128;
                6, 7:    g = int'($urandom_range(16, 191));
                8:       g = int'($urandom_range(3, 15));
                default: g = int'($urandom_range(195, 230));
            endcase
            drive_half(g);
        end
        drive_half(40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
